mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum consecutive GRANT cycles per owner; legal range 2..255; used only when the timeout feature is compiled in.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  level request per requester; bit i belongs to requester i.
REQ-005 grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-006 sel  output  2  registered owner index, driving the 2-bit select of the shared 16-bit 4:1 datapath mux.
REQ-007 busy  output  1  high while state is GRANT or RELEASE.
REQ-008 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-010 IDLE, any req bit high: select winner round-robin starting at index ptr, ascending modulo 4; next cycle enter GRANT with grant[winner]=1 and sel=winner.
REQ-011 Request-to-grant latency SHALL be exactly 1 cycle: req sampled at edge N, grant visible after edge N+1.
REQ-012 IDLE, req==0: remain in IDLE; grant=0; sel holds its last value.
REQ-013 GRANT: hold grant and sel unchanged while req[owner]=1; requests from other requesters SHALL NOT pre-empt the owner.
REQ-014 GRANT, req[owner]=0: enter RELEASE; grant=0 in RELEASE.
REQ-015 RELEASE SHALL last exactly 1 turnaround cycle with sel held, then go to IDLE; no back-to-back grant without this bubble.
REQ-016 On leaving GRANT, ptr SHALL update to (owner+1) mod 4, with wrap-around from 3 to 0.
REQ-017 A requester that drops req in IDLE before being granted SHALL NOT be granted; no request is latched.
REQ-018 grant SHALL be one-hot or zero in every cycle, and sel SHALL equal the index of the set grant bit whenever grant!=0.
REQ-019 busy SHALL be combinationally derived from state only.

Reset
REQ-020 While reset is high at a rising clk edge: state=IDLE, grant=0, sel=2'b00, ptr=0, busy=0, timeout=0, timeout counter=0.
REQ-021 Reset asserted mid-GRANT SHALL drop grant at that same edge, with no RELEASE cycle and no timeout pulse.
REQ-022 Reset SHALL have priority over all other events in the same cycle.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit counter cleared on entry to GRANT and incremented each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN defined:
- if the owner is still requesting after TIMEOUT_CYCLES GRANT cycles, the block SHALL force RELEASE, pulse timeout for 1 cycle coincident with the first RELEASE cycle, and advance ptr per REQ-016;
- if the owner drops req in the same cycle the limit is reached, the release SHALL be normal, with timeout=0.
REQ-025 Without ARB_TIMEOUT_EN: no counter SHALL exist, timeout SHALL be constant 0, and grant SHALL be held indefinitely while req[owner]=1.

Verification
REQ-026 Reset, then req=4'b0001 held 3 cycles and then dropped -> grant=4'b0001 and sel=0 one cycle after the first req sample; 1 RELEASE cycle with busy=1 and grant=0; then IDLE.
REQ-027 req=4'b1111 held continuously, each owner dropping after 2 cycles and re-raising -> grant order 0,1,2,3,0 with a one-cycle zero-grant bubble between owners.
REQ-028 Owner 2 granted, req=4'b0110 applied -> grant stays 4'b0100 until req[2]=0, then requester 1 is granted after RELEASE (ptr=3 wraps to 0, then 1 wins).
REQ-029 Reset asserted on the 2nd GRANT cycle of owner 3 -> at that edge grant=0, sel=0, busy=0; next arbitration starts from requester 0.
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, req=4'b0011 held -> owner 0 granted 4 cycles, timeout=1 for exactly 1 cycle, then owner 1 granted; without the macro, owner 0 is held for more than 100 cycles and timeout stays 0.
REQ-031 ARB_TIMEOUT_EN defined, owner drops req in the cycle the counter reaches TIMEOUT_CYCLES -> normal RELEASE with timeout=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : 4-requester round-robin owner arbiter for a shared 16-bit
// 4:1 datapath mux. Optional forced release under macro ARB_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] grant_next;
  logic [1:0] sel_next;
  logic [1:0] ptr, ptr_next;
  logic [1:0] winner;
  logic       found;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  // Counter holds the number of GRANT cycles already completed by the owner.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_next;
  logic       timeout_next;
`endif

  // First requesting index at or after ptr, ascending and wrapping.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    sel_next   = sel;
    ptr_next   = ptr;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt;
    timeout_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          grant_next = 4'b0001 << winner;
          sel_next   = winner;
`ifdef ARB_TIMEOUT_EN
          cnt_next   = 8'd0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        cnt_next = cnt + 8'd1;
`endif
        if (!req[sel]) begin
          state_next = RELEASE;
          grant_next = 4'b0000;
          ptr_next   = sel + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == LIMIT) begin
          state_next   = RELEASE;
          grant_next   = 4'b0000;
          ptr_next     = sel + 2'd1;
          timeout_next = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      sel   <= sel_next;
      ptr   <= ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 8'd0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      timeout <= timeout_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state == GRANT) || (state == RELEASE);

endmodule

`default_nettype wire
